// File: rtl/mac_pkg.sv
// Shared types for the MAC feeder: controller state encoding and counter sizing.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    CAPTURE,
    RESULT
  } feeder_state_e;

  // Counter must reach VEC_LEN, so it needs room for one value past the last index.
  function automatic int cnt_w(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/mac_feeder.sv
// Feeds one MAC unit: clears it, streams VEC_LEN operand pairs through a joint
// A/B handshake, then captures the accumulator onto a valid/ready result port.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  output logic [3*DATA_WIDTH-1:0] res_data,
  input  logic                    res_ready
);

  localparam int CW = cnt_w(VEC_LEN);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  feeder_state_e state;
  logic [CW-1:0] count;
  logic          fire;

  // Neither stream is consumed unless both have an operand ready.
  assign fire = (state == ACCUM) && a_valid && b_valid;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          count <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          if (fire) begin
            count <= count + CW'(1);
            if (count == LAST) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The MAC accumulator is registered, so the last product lands here.
          res_data <= mac_cout;
          state    <= RESULT;
        end
        RESULT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign a_ready   = fire;
  assign b_ready   = fire;
  assign mac_en    = fire;
  assign mac_clr   = (state == CLEAR);
  assign res_valid = (state == RESULT);
  assign mac_a     = a_data;
  assign mac_b     = b_data;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: two instances (VEC_LEN 4 and 8), each with a
// behavioural MAC, driven through shared streams and checked against a dot-product model.
module tb_mac_feeder;

  localparam int DW = 8;
  localparam int RW = 3 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel;
  logic          start, a_valid, b_valid, res_ready;
  logic [DW-1:0] a_data, b_data;

  logic          busy4, a_ready4, b_ready4, mac_en4, mac_clr4, res_valid4;
  logic [DW-1:0] mac_a4, mac_b4;
  logic [RW-1:0] mac_cout4, res_data4;
  logic          busy8, a_ready8, b_ready8, mac_en8, mac_clr8, res_valid8;
  logic [DW-1:0] mac_a8, mac_b8;
  logic [RW-1:0] mac_cout8, res_data8;

  logic          busy, a_ready, b_ready, mac_en, mac_clr, res_valid;
  logic [DW-1:0] mac_a, mac_b;
  logic [RW-1:0] res_data;

  logic [DW-1:0] av[8];
  logic [DW-1:0] bv[8];

  int n_pass = 0;
  int n_total = 0;

  mac_feeder #(.DATA_WIDTH(DW), .VEC_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .busy(busy4),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .mac_en(mac_en4), .mac_clr(mac_clr4), .mac_a(mac_a4), .mac_b(mac_b4),
    .mac_cout(mac_cout4), .res_valid(res_valid4), .res_data(res_data4),
    .res_ready(res_ready && !sel)
  );

  mac_feeder #(.DATA_WIDTH(DW), .VEC_LEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .busy(busy8),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready8),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready8),
    .mac_en(mac_en8), .mac_clr(mac_clr8), .mac_a(mac_a8), .mac_b(mac_b8),
    .mac_cout(mac_cout8), .res_valid(res_valid8), .res_data(res_data8),
    .res_ready(res_ready && sel)
  );

  // Behavioural MAC units: clear wins, otherwise accumulate a*b modulo 2**RW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mac_cout4 <= '0;
    else if (mac_clr4) mac_cout4 <= '0;
    else if (mac_en4)  mac_cout4 <= mac_cout4 + RW'(mac_a4) * RW'(mac_b4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mac_cout8 <= '0;
    else if (mac_clr8) mac_cout8 <= '0;
    else if (mac_en8)  mac_cout8 <= mac_cout8 + RW'(mac_a8) * RW'(mac_b8);
  end

  always_comb begin
    busy = busy4; a_ready = a_ready4; b_ready = b_ready4; mac_en = mac_en4;
    mac_clr = mac_clr4; res_valid = res_valid4; mac_a = mac_a4; mac_b = mac_b4;
    res_data = res_data4;
    if (sel) begin
      busy = busy8; a_ready = a_ready8; b_ready = b_ready8; mac_en = mac_en8;
      mac_clr = mac_clr8; res_valid = res_valid8; mac_a = mac_a8; mac_b = mac_b8;
      res_data = res_data8;
    end
  end

  function automatic logic [RW-1:0] dot_ref(input int vl);
    longint unsigned s = 0;
    for (int i = 0; i < vl; i++) s += longint'(av[i]) * longint'(bv[i]);
    return RW'(s);
  endfunction

  // One full dot product. mode: 0 = both always valid, 1 = b valid on alternate
  // cycles, 2 = both random. hold = cycles of res_ready low; poke = start in RESULT.
  task automatic run_dot(input string tag, input int vl, input int mode, input int hold,
                         input bit poke, output logic [RW-1:0] result);
    int ia = 0, ib = 0, fires = 0, cyc, last_fire = -1, first_fire = -1;
    bit hs_ok = 1'b1, stable_ok = 1'b1, exp_fire;
    logic [RW-1:0] expv, held;
    expv = dot_ref(vl);
    @(negedge clk); start = 1'b1; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk); start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_data = av[0]; b_data = bv[0]; #1;
    cyc = 1;
    n_total++;
    if ({mac_clr, busy, a_ready, b_ready, mac_en} !== 5'b11000)
      $display("FAIL %s clear_cycle: clr/busy/ar/br/en=%b want 11000", tag,
               {mac_clr, busy, a_ready, b_ready, mac_en});
    else n_pass++;
    while (cyc < 300) begin
      @(negedge clk); cyc++;
      a_valid = (mode == 2) ? ($urandom_range(0, 99) < 60) : 1'b1;
      b_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < 60);
      a_data = (ia < vl) ? av[ia] : 8'hA5;
      b_data = (ib < vl) ? bv[ib] : 8'h5A;
      #1;
      if (res_valid === 1'b1) break;
      exp_fire = (fires < vl) && a_valid && b_valid;
      if (a_ready !== exp_fire || b_ready !== exp_fire || mac_en !== exp_fire ||
          mac_clr !== 1'b0 || (mac_en === 1'b1 && (mac_a !== a_data || mac_b !== b_data))) begin
        if (hs_ok)
          $display("  %s handshake error at cycle %0d: ar=%b br=%b en=%b clr=%b exp_fire=%b",
                   tag, cyc, a_ready, b_ready, mac_en, mac_clr, exp_fire);
        hs_ok = 1'b0;
      end
      if (a_ready === 1'b1) ia++;
      if (b_ready === 1'b1) ib++;
      if (mac_en === 1'b1) begin
        fires++;
        last_fire = cyc;
        if (first_fire < 0) first_fire = cyc;
      end
    end
    n_total++;
    if (res_valid !== 1'b1) $display("FAIL %s res_valid_seen: got %b want 1", tag, res_valid);
    else n_pass++;
    n_total++;
    if (hs_ok !== 1'b1) $display("FAIL %s handshake: got error want none", tag);
    else n_pass++;
    n_total++;
    if (fires != vl || ia != vl || ib != vl)
      $display("FAIL %s fire_count: fires=%0d a=%0d b=%0d want %0d", tag, fires, ia, ib, vl);
    else n_pass++;
    n_total++;
    if (cyc - last_fire != 2)
      $display("FAIL %s last_fire_to_valid: got %0d want 2", tag, cyc - last_fire);
    else n_pass++;
    if (mode == 0) begin
      n_total++;
      if (first_fire != 2 || cyc != vl + 3)
        $display("FAIL %s latency: first_fire=%0d start_to_valid=%0d want 2 and %0d",
                 tag, first_fire, cyc, vl + 3);
      else n_pass++;
    end
    n_total++;
    if (res_data !== expv) $display("FAIL %s res_data: got %0d want %0d", tag, res_data, expv);
    else n_pass++;

    held = res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = poke && (h == 1); a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b0;
      #1;
      if (res_valid !== 1'b1 || res_data !== held || a_ready !== 1'b0 ||
          b_ready !== 1'b0 || busy !== 1'b1) stable_ok = 1'b0;
    end
    if (hold > 0) begin
      n_total++;
      if (stable_ok !== 1'b1) $display("FAIL %s result_hold: got unstable want stable", tag);
      else n_pass++;
    end
    @(negedge clk); res_ready = 1'b1; start = poke; #1;
    @(negedge clk); res_ready = 1'b0; start = 1'b0; #1;
    n_total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== expv)
      $display("FAIL %s accept_to_idle: valid=%b busy=%b data=%0d want 0 0 %0d",
               tag, res_valid, busy, res_data, expv);
    else n_pass++;
    if (poke) begin
      @(negedge clk); #1;
      n_total++;
      if (busy !== 1'b0 || mac_clr !== 1'b0)
        $display("FAIL %s start_ignored: busy=%b clr=%b want 0 0", tag, busy, mac_clr);
      else n_pass++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    result = res_data;
  endtask

  task automatic load_scenario1();
    for (int i = 0; i < 4; i++) begin
      av[i] = DW'(i + 1);
      bv[i] = DW'(i + 5);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; start = 1'b1; res_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      n_total++;
      if ({busy, a_ready, b_ready, mac_en, mac_clr, res_valid} !== 6'b0 || res_data !== '0)
        $display("FAIL reset_state inst%0d: ctl=%b data=%0d want 0 0", s,
                 {busy, a_ready, b_ready, mac_en, mac_clr, res_valid}, res_data);
      else n_pass++;
    end
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0; sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [RW-1:0] r;
    sel = 1'b0; load_scenario1();
    run_dot("basic", 4, 0, 0, 1'b0, r);
  endtask

  task automatic test_max_operands();
    logic [RW-1:0] r;
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin av[i] = 8'hFF; bv[i] = 8'hFF; end
    run_dot("max", 8, 0, 0, 1'b0, r);
    n_total++;
    if (r !== 24'd520200) $display("FAIL max_value: got %0d want 520200", r);
    else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_stall();
    logic [RW-1:0] r;
    sel = 1'b0; load_scenario1();
    run_dot("stall", 4, 1, 0, 1'b0, r);
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] r;
    sel = 1'b0; load_scenario1();
    run_dot("backpressure", 4, 0, 5, 1'b1, r);
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] r;
    sel = 1'b0; load_scenario1();
    run_dot("b2b_first", 4, 0, 0, 1'b0, r);
    for (int i = 0; i < 4; i++) begin av[i] = 8'd1; bv[i] = 8'd2; end
    run_dot("b2b_second", 4, 0, 0, 1'b0, r);
    n_total++;
    if (r !== 24'd8) $display("FAIL b2b_value: got %0d want 8", r);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] r;
    sel = 1'b0; load_scenario1();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = av[0]; b_data = bv[0];
    @(negedge clk); a_data = av[0]; b_data = bv[0];
    @(negedge clk); a_data = av[1]; b_data = bv[1];
    @(negedge clk); a_data = av[2]; b_data = bv[2]; rst_n = 1'b0; #1;
    n_total++;
    if ({busy, a_ready, b_ready, mac_en, mac_clr, res_valid} !== 6'b0 || res_data !== '0)
      $display("FAIL reset_mid: ctl=%b data=%0d want 0 0",
               {busy, a_ready, b_ready, mac_en, mac_clr, res_valid}, res_data);
    else n_pass++;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_dot("after_reset", 4, 0, 0, 1'b0, r);
  endtask

  task automatic test_random();
    logic [RW-1:0] r;
    int vl;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      vl = sel ? 8 : 4;
      for (int i = 0; i < 8; i++) begin
        av[i] = DW'($urandom_range(0, 255));
        bv[i] = DW'($urandom_range(0, 255));
      end
      run_dot($sformatf("random%0d", it), vl, 2, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), r);
    end
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    a_data = '0; b_data = '0;
    test_reset();
    test_basic();
    test_max_operands();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
